frm2fifo_3map: RTL

- Downstream stage of the 3-map FIFO-to-frame unpacker.
- Consumes the 24-bit frame interface (val/rdy, sof/eof/sol/eol) and splits each pixel into three 8-bit channels.
- Packs each channel into FIFO_DATA_WIDTH words and pushes them into three per-channel write FIFOs, which feed the AXI write-back path.
- Provides frame-level sequencing (start on enable edge, SOF sync, end-of-frame flush, done status).

---
 rtl/frm2fifo_3map_pkg.sv | 28 ++
 rtl/frm2fifo_3map_byte_packer.sv | 52 +++++
 rtl/frm2fifo_3map.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/frm2fifo_3map_pkg.sv
// Shared types and constants for the 3-map frame-to-FIFO packer.
// State encoding, word geometry helpers and protocol-error bit positions.
package frm2fifo_3map_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_RUN      = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int DEF_FIFO_DW = 64;

  localparam int ERR_EOL = 0;
  localparam int ERR_EOF = 1;
  localparam int ERR_SOF = 2;

  function automatic int bpw_of(input int w);
    return w / 8;
  endfunction

  // byte_cnt needs at least one bit even for single-byte words
  function automatic int bcw_of(input int w);
    return (w / 8 > 1) ? $clog2(w / 8) : 1;
  endfunction

endpackage

// File: rtl/frm2fifo_3map_byte_packer.sv
// One channel: gathers bytes into a FIFO word and registers the finished word.
// Bytes above the write index stay zero, so a short eof word is zero-padded.
module frm2fifo_3map_byte_packer #(
  parameter int W   = 64,
  parameter int BCW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           wr,
  input  logic           en,
  input  logic [BCW-1:0] idx,
  input  logic           restart,
  input  logic           done,
  input  logic [7:0]     din,
  output logic [W-1:0]   pushdata
);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] pushdata_q, pushdata_d;
  logic [W-1:0] word;

  always_comb begin
    word = restart ? '0 : acc_q;
    word[idx*8 +: 8] = en ? din : 8'h00;
    acc_d      = acc_q;
    pushdata_d = pushdata_q;
    if (clr) begin
      acc_d = '0;
    end else if (wr) begin
      if (done) begin
        pushdata_d = word;
        acc_d      = '0;
      end else begin
        acc_d = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      pushdata_q <= '0;
    end else begin
      acc_q      <= acc_d;
      pushdata_q <= pushdata_d;
    end
  end

  assign pushdata = pushdata_q;

endmodule

// File: rtl/frm2fifo_3map.sv
// Splits 24-bit frame pixels into three byte channels and pushes packed words to per-channel FIFOs.
// Optional protocol checking under FRM2FIFO_PROTO_CHK_EN; without it sts_proto_err is 0.
module frm2fifo_3map
  import frm2fifo_3map_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = DEF_FIFO_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_blk_en,
  input  logic                       cfg_map0_en,
  input  logic                       cfg_map1_en,
  input  logic                       cfg_map2_en,
  input  logic [10:0]                cfg_img_width,
  input  logic [10:0]                cfg_img_height,
  input  logic                       frm_val,
  input  logic [23:0]                frm_data,
  input  logic                       frm_sof,
  input  logic                       frm_eof,
  input  logic                       frm_sol,
  input  logic                       frm_eol,
  output logic                       frm_rdy,
  input  logic                       fifo_ch0_full,
  input  logic                       fifo_ch1_full,
  input  logic                       fifo_ch2_full,
  output logic                       fifo_ch0_push,
  output logic                       fifo_ch1_push,
  output logic                       fifo_ch2_push,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_ch0_pushdata,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_ch1_pushdata,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_ch2_pushdata,
  output logic                       sts_frm_done,
  output logic [2:0]                 sts_proto_err
);

  localparam int BPW = bpw_of(FIFO_DATA_WIDTH);
  localparam int BCW = bcw_of(FIFO_DATA_WIDTH);

  state_t          state_q, state_d;
  logic            blk_en_d_q;
  logic [2:0]      map_en_q, map_en_d;
  logic [10:0]     pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d, wr_idx;
  logic            wr_pend_q, wr_pend_d, done_q, done_d;
  logic [2:0]      err_q, err_d, err_set;
  logic [2:0]      cfg_map, full_vec;
  logic            start, load, push_ok, push_any, acc, take, restart, word_done, clr_acc;
  logic            unused_sol;
  logic [FIFO_DATA_WIDTH-1:0] pd [3];

  assign unused_sol = frm_sol;
  assign cfg_map    = {cfg_map2_en, cfg_map1_en, cfg_map0_en};
  assign full_vec   = {fifo_ch2_full, fifo_ch1_full, fifo_ch0_full};
  assign start      = cfg_blk_en & ~blk_en_d_q;
  assign load       = start & (|cfg_map) & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign push_ok    = &(~map_en_q | ~full_vec);
  assign push_any   = wr_pend_q & push_ok;

  always_comb begin
    frm_rdy = 1'b0;
    case (state_q)
      ST_WAIT_SOF: frm_rdy = 1'b1;
      ST_RUN:      frm_rdy = ~wr_pend_q | push_ok;
      default:     frm_rdy = 1'b0;
    endcase
  end

  assign acc  = frm_val & frm_rdy;
  assign take = acc & ((state_q == ST_RUN) | ((state_q == ST_WAIT_SOF) & frm_sof));

`ifdef FRM2FIFO_PROTO_CHK_EN
  // A sof inside RUN resynchronises: the partial word is dropped and this pixel becomes byte 0
  assign restart = take & (state_q == ST_RUN) & frm_sof;
  always_comb begin
    err_set          = 3'b000;
    err_set[ERR_EOL] = take & ((frm_eol & (pix_cnt_q != 11'd1)) | (~frm_eol & (pix_cnt_q == 11'd1)));
    err_set[ERR_EOF] = take & frm_eof & ~((line_cnt_q == 11'd1) & (pix_cnt_q == 11'd1));
    err_set[ERR_SOF] = restart;
  end
`else
  assign restart = 1'b0;
  assign err_set = 3'b000;
`endif

  assign wr_idx    = restart ? '0 : byte_cnt_q;
  assign word_done = take & ((wr_idx == BCW'(BPW - 1)) | frm_eof);
  assign clr_acc   = ~cfg_blk_en | load;

  always_comb begin
    state_d    = state_q;
    map_en_d   = map_en_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wr_pend_d  = wr_pend_q;
    done_d     = done_q;
    err_d      = err_q | err_set;

    if (take) begin
      byte_cnt_d = word_done ? '0 : wr_idx + 1'b1;
      pix_cnt_d  = frm_eol ? cfg_img_width : pix_cnt_q - 11'd1;
      if (frm_eol) line_cnt_d = line_cnt_q - 11'd1;
    end
    if (push_any)  wr_pend_d = 1'b0;
    if (word_done) wr_pend_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          state_d    = ST_WAIT_SOF;
          map_en_d   = cfg_map;
          pix_cnt_d  = cfg_img_width;
          line_cnt_d = cfg_img_height;
          byte_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 3'b000;
        end
      end
      ST_WAIT_SOF, ST_RUN: begin
        if (take) state_d = frm_eof ? ST_FLUSH : ST_RUN;
      end
      ST_FLUSH: begin
        if (push_any) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!cfg_blk_en) begin
      state_d    = ST_IDLE;
      wr_pend_d  = 1'b0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_en_d_q <= 1'b0;
      map_en_q   <= 3'b000;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      byte_cnt_q <= '0;
      wr_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      blk_en_d_q <= cfg_blk_en;
      map_en_q   <= map_en_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wr_pend_q  <= wr_pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_pack
    frm2fifo_3map_byte_packer #(.W(FIFO_DATA_WIDTH), .BCW(BCW)) u_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_acc),
      .wr       (take),
      .en       (map_en_q[i]),
      .idx      (wr_idx),
      .restart  (restart),
      .done     (word_done),
      .din      (frm_data[8*i +: 8]),
      .pushdata (pd[i])
    );
  end

  assign fifo_ch0_push     = push_any & map_en_q[0];
  assign fifo_ch1_push     = push_any & map_en_q[1];
  assign fifo_ch2_push     = push_any & map_en_q[2];
  assign fifo_ch0_pushdata = pd[0];
  assign fifo_ch1_pushdata = pd[1];
  assign fifo_ch2_pushdata = pd[2];
  assign sts_frm_done      = done_q;
  assign sts_proto_err     = err_q;

endmodule
